// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its UART dump engine.
package regfile_pkg;

    localparam int UART_W   = 8;
    localparam int REG_ZERO = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_TX   = 3'd2,
        SEND      = 3'd3,
        WAIT_BUSY = 3'd4,
        NEXT      = 3'd5
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump engine: walks a register range, snapshots each word and streams it MSB-first
// to the UART over a valid/busy handshake.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_BUS_WIDTH = 5,
    parameter int DATA_BUS_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dump_start,
    input  logic [ADDR_BUS_WIDTH-1:0] dump_first,
    input  logic [ADDR_BUS_WIDTH-1:0] dump_last,
    input  logic                      tx_busy,
    input  logic [DATA_BUS_WIDTH-1:0] rd_data,
    output logic [ADDR_BUS_WIDTH-1:0] rd_addr,
    output logic                      dump_busy,
    output logic                      dump_done,
    output logic [UART_W-1:0]         tx_data,
    output logic                      tx_valid
);

    localparam int BYTES = DATA_BUS_WIDTH / UART_W;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

    dump_state_t               state;
    logic [ADDR_BUS_WIDTH-1:0] idx;
    logic [ADDR_BUS_WIDTH-1:0] last;
    logic [BCW-1:0]            byte_cnt;
    logic [DATA_BUS_WIDTH-1:0] snapshot;
    logic [DATA_BUS_WIDTH-1:0] shifted;
    logic                      skip;

    assign rd_addr = idx;
    // Byte byte_cnt counted from the MSB ends up in the top byte lane.
    assign shifted = snapshot << {byte_cnt, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            last      <= '0;
            byte_cnt  <= '0;
            snapshot  <= '0;
            skip      <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            dump_busy <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            tx_valid  <= 1'b0;
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        idx  <= dump_first;
                        last <= dump_last;
                        if (dump_first > dump_last) begin
                            dump_done <= 1'b1;
                        end else begin
                            dump_busy <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    snapshot <= rd_data;
                    byte_cnt <= '0;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (!tx_busy) begin
                        tx_valid <= 1'b1;
                        tx_data  <= shifted[DATA_BUS_WIDTH-1 -: UART_W];
                        state    <= SEND;
                    end
                end
                SEND: begin
                    skip  <= 1'b1;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // UART raises busy only one cycle after the strobe.
                    if (skip)
                        skip <= 1'b0;
                    else if (!tx_busy)
                        state <= NEXT;
                end
                NEXT: begin
                    if (byte_cnt < LAST_BYTE) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        state    <= WAIT_TX;
                    end else if (idx == last) begin
                        dump_done <= 1'b1;
                        dump_busy <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Parametrised register file with a UART dump engine. Define REGFILE_BYPASS_EN to
// forward a same-cycle write onto the read ports and the dump snapshot port.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int ADDR_BUS_WIDTH = 5,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int DEBUG_REG      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_BUS_WIDTH-1:0] addr1,
    input  logic [ADDR_BUS_WIDTH-1:0] addr2,
    input  logic [ADDR_BUS_WIDTH-1:0] addr3,
    input  logic [DATA_BUS_WIDTH-1:0] write_data,
    input  logic                      write_en,
    output logic [DATA_BUS_WIDTH-1:0] read_data1,
    output logic [DATA_BUS_WIDTH-1:0] read_data2,
    output logic [UART_W-1:0]         debug_word,
    input  logic                      dump_start,
    input  logic [ADDR_BUS_WIDTH-1:0] dump_first,
    input  logic [ADDR_BUS_WIDTH-1:0] dump_last,
    output logic                      dump_busy,
    output logic                      dump_done,
    output logic [UART_W-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_busy
);

    localparam int DEPTH = 2 ** ADDR_BUS_WIDTH;
    localparam logic [ADDR_BUS_WIDTH-1:0] ZERO_IDX = ADDR_BUS_WIDTH'(REG_ZERO);
    localparam logic [ADDR_BUS_WIDTH-1:0] DBG_IDX  = ADDR_BUS_WIDTH'(DEBUG_REG);

    logic [DATA_BUS_WIDTH-1:0] regs [DEPTH];
    logic [ADDR_BUS_WIDTH-1:0] addr_dump;
    logic [DATA_BUS_WIDTH-1:0] read_dump;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (write_en && addr3 != ZERO_IDX) begin
            regs[addr3] <= write_data;
        end
    end

    function automatic logic [DATA_BUS_WIDTH-1:0] rd_port(input logic [ADDR_BUS_WIDTH-1:0] a,
                                                          input logic [DATA_BUS_WIDTH-1:0] stored);
`ifdef REGFILE_BYPASS_EN
        if (a == ZERO_IDX)                   return '0;
        else if (write_en && addr3 == a)     return write_data;
        else                                 return stored;
`else
        if (a == ZERO_IDX)                   return '0;
        else                                 return stored;
`endif
    endfunction

    assign read_data1 = rd_port(addr1, regs[addr1]);
    assign read_data2 = rd_port(addr2, regs[addr2]);
    assign read_dump  = rd_port(addr_dump, regs[addr_dump]);
    assign debug_word = regs[DBG_IDX][UART_W-1:0];

    regfile_dump_ctrl #(
        .ADDR_BUS_WIDTH (ADDR_BUS_WIDTH),
        .DATA_BUS_WIDTH (DATA_BUS_WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_first (dump_first),
        .dump_last  (dump_last),
        .tx_busy    (tx_busy),
        .rd_data    (read_dump),
        .rd_addr    (addr_dump),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid)
    );

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: register access, dump byte order/latency, empty
// range, reset abort and optional write bypass, against a 10-cycle UART busy model.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  addr1 = '0, addr2 = '0, addr3 = '0;
    logic [31:0] write_data = '0;
    logic        write_en = 1'b0;
    logic [31:0] read_data1, read_data2;
    logic [7:0]  debug_word;
    logic        dump_start = 1'b0;
    logic [4:0]  dump_first = '0, dump_last = '0;
    logic        dump_busy, dump_done;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;

    int n_chk = 0;
    int n_err = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [7:0] cap [$];

    always #5 clk = ~clk;

    regfile_dump dut (
        .clk(clk), .rst(rst),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .write_data(write_data), .write_en(write_en),
        .read_data1(read_data1), .read_data2(read_data2),
        .debug_word(debug_word),
        .dump_start(dump_start), .dump_first(dump_first), .dump_last(dump_last),
        .dump_busy(dump_busy), .dump_done(dump_done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy)
    );

    // UART model: busy for 10 cycles starting the cycle after each strobe.
    always @(posedge clk) begin
        if (tx_valid)          busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (tx_valid)  cap.push_back(tx_data);
        if (dump_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr3 = a; write_data = d; write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    // Returns at the negedge of the cycle after dump_start was high.
    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        dump_first = f; dump_last = l; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            if (dump_done) begin seen = 1; break; end
            tick();
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) chk({tag, "_busy_at_done"}, 32'(dump_busy), 32'd0);
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_nbytes"}, 32'(cap.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp[i]));
    endtask

    initial begin
        int d0;
        bit got2;
        repeat (3) tick();
        addr1 = 5'd5;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(dump_busy), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        chk("rst_debug", 32'(debug_word), 32'd0);
        chk("rst_rd1", read_data1, 32'd0);
        rst = 1'b0;
        tick();

        // Basic write/read and r0 hardwiring
        wr(5'd5, 32'h1234_5678);
        chk("rd_r5", read_data1, 32'h1234_5678);
        wr(5'd0, 32'hFFFF_FFFF);
        addr2 = 5'd0;
        chk("rd_r0", read_data2, 32'd0);
        wr(5'd4, 32'h0000_00AB);
        chk("debug_word", 32'(debug_word), 32'h0000_00AB);

        // Two-register dump with latency checks and an ignored start mid-dump
        wr(5'd2, 32'hA1B2_C3D4);
        wr(5'd3, 32'h0102_0304);
        wr(5'd5, 32'h5555_5555);
        cap.delete();
        d0 = done_cnt;
        start_dump(5'd2, 5'd3);
        chk("lat_busy_c1", 32'(dump_busy), 32'd1);
        chk("lat_valid_c1", 32'(tx_valid), 32'd0);
        tick();
        chk("lat_valid_c2", 32'(tx_valid), 32'd0);
        tick();
        chk("lat_valid_c3", 32'(tx_valid), 32'd1);
        chk("lat_data_c3", 32'(tx_data), 32'h0000_00A1);
        dump_first = 5'd5; dump_last = 5'd5; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_done("d23", 400);
        repeat (40) tick();
        chk_bytes("d23", '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04});
        chk("d23_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Top register, no wrap back to r0
        wr(5'd31, 32'h7FFF_FFFF);
        cap.delete();
        d0 = done_cnt;
        start_dump(5'd31, 5'd31);
        wait_done("d31", 300);
        repeat (40) tick();
        chk_bytes("d31", '{8'h7F, 8'hFF, 8'hFF, 8'hFF});
        chk("d31_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Empty range: done one cycle after start, nothing sent
        cap.delete();
        start_dump(5'd6, 5'd4);
        chk("empty_done_c1", 32'(dump_done), 32'd1);
        chk("empty_busy_c1", 32'(dump_busy), 32'd0);
        tick();
        chk("empty_done_c2", 32'(dump_done), 32'd0);
        repeat (10) tick();
        chk("empty_nbytes", 32'(cap.size()), 32'd0);

        // Reset abort after the second byte of a three-register dump
        wr(5'd1, 32'hCAFE_0001);
        cap.delete();
        d0 = done_cnt;
        start_dump(5'd1, 5'd3);
        got2 = 0;
        for (int i = 0; i < 200; i++) begin
            if (cap.size() >= 2) begin got2 = 1; break; end
            tick();
        end
        chk("abort_two_bytes", 32'(got2), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy", 32'(dump_busy), 32'd0);
        chk("abort_done", 32'(dump_done), 32'd0);
        rst = 1'b0;
        tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk_bytes("abort", '{8'hCA, 8'hFE});

        // Dump accepted after the abort; storage was cleared by reset
        wr(5'd1, 32'h1122_3344);
        cap.delete();
        start_dump(5'd1, 5'd1);
        chk("restart_busy", 32'(dump_busy), 32'd1);
        wait_done("restart", 300);
        chk_bytes("restart", '{8'h11, 8'h22, 8'h33, 8'h44});

        // Same-cycle write forwarding (or not)
        wr(5'd7, 32'h0BAD_0007);
        addr1 = 5'd7; addr3 = 5'd7; write_data = 32'hDEAD_0001; write_en = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_rd1", read_data1, 32'hDEAD_0001);
`else
        chk("bypass_rd1", read_data1, 32'h0BAD_0007);
`endif
        tick();
        write_en = 1'b0;
        chk("after_write_rd1", read_data1, 32'hDEAD_0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
